wb_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one Wishbone classic slave port (peripheral bus,

---
 rtl/wb_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave port between several masters.
// The grant is held for a whole bus cycle, and a watchdog aborts cycles the slave never answers.
module wb_rr_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int GW            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
   localparam int SW            = DATA_WIDTH / 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_MASTERS-1:0]            m_cyc,
   input  logic [NUM_MASTERS-1:0]            m_stb,
   input  logic [NUM_MASTERS-1:0]            m_we,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_w,
   input  logic [NUM_MASTERS*SW-1:0]         m_sel,
   output logic [DATA_WIDTH-1:0]             m_dat_r,
   output logic [NUM_MASTERS-1:0]            m_ack,
   output logic [NUM_MASTERS-1:0]            m_err,
   output logic                              s_cyc,
   output logic                              s_stb,
   output logic                              s_we,
   output logic [ADDR_WIDTH-1:0]             s_adr,
   output logic [DATA_WIDTH-1:0]             s_dat_w,
   output logic [SW-1:0]                     s_sel,
   input  logic [DATA_WIDTH-1:0]             s_dat_r,
   input  logic                              s_ack,
   input  logic                              s_err,
   output logic [GW-1:0]                     grant,
   output logic                              busy
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } state_e;

   state_e        state_q;
   logic [GW-1:0] grant_q;
   logic [GW-1:0] grant_d;
   logic [CW-1:0] wdCnt_q;
   logic          errPulse_q;
   logic          wdFire;
   logic          ownerCyc;

   // Search starts just after the last owner so every requester gets a turn.
   always_comb begin
      int   idx;
      logic found;
      grant_d = grant_q;
      found   = 1'b0;
      idx     = 0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = (int'(grant_q) + i) % NUM_MASTERS;
         if (!found && m_cyc[idx]) begin
            grant_d = GW'(idx);
            found   = 1'b1;
         end
      end
   end

   assign ownerCyc = m_cyc[grant_q];
   assign wdFire   = (TIMEOUT_CYCLES != 0) && s_stb && !s_ack && !s_err
                     && (wdCnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= GW'(NUM_MASTERS - 1);
         wdCnt_q    <= '0;
         errPulse_q <= 1'b0;
      end else begin
         errPulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|m_cyc) begin
                  grant_q <= grant_d;
                  wdCnt_q <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (!ownerCyc) begin
                  state_q <= IDLE;
               end else if (s_ack || s_err) begin
                  wdCnt_q <= '0;
               end else if (wdFire) begin
                  wdCnt_q    <= CW'(TIMEOUT_CYCLES);
                  errPulse_q <= 1'b1;
                  state_q    <= ABORT;
               end else if (s_stb && wdCnt_q != '1) begin
                  wdCnt_q <= wdCnt_q + 1'b1;
               end
            end
            ABORT: begin
               if (!ownerCyc) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The slave only ever sees the owner's signals while BUSY; IDLE and ABORT keep the bus quiet.
   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = m_we[grant_q];
      s_adr   = m_adr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_w = m_dat_w[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      s_sel   = m_sel[int'(grant_q)*SW +: SW];
      m_ack   = '0;
      m_err   = '0;
      if (state_q == BUSY) begin
         s_cyc          = ownerCyc;
         s_stb          = m_stb[grant_q];
         m_ack[grant_q] = s_ack;
         m_err[grant_q] = s_err;
      end
      if (errPulse_q) m_err[grant_q] = 1'b1;
   end

   assign m_dat_r = s_dat_r;
   assign grant   = grant_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed testbench for wb_rr_arbiter with two masters and an 8-cycle watchdog.
// The slave side is driven by hand so each acknowledge lands on a known cycle.
module tb_wb_rr_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rstN;
   logic [N-1:0]    mCyc, mStb, mWe;
   logic [N*AW-1:0] mAdr;
   logic [N*DW-1:0] mDatW;
   logic [N*4-1:0]  mSel;
   logic [DW-1:0]   mDatR;
   logic [N-1:0]    mAck, mErr;
   logic            sCyc, sStb, sWe;
   logic [AW-1:0]   sAdr;
   logic [DW-1:0]   sDatW;
   logic [3:0]      sSel;
   logic [DW-1:0]   sDatR;
   logic            sAck, sErr;
   logic [0:0]      grant;
   logic            busy;

   int compCnt = 0;
   int failCnt = 0;

   wb_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rstN),
      .m_cyc(mCyc), .m_stb(mStb), .m_we(mWe), .m_adr(mAdr), .m_dat_w(mDatW), .m_sel(mSel),
      .m_dat_r(mDatR), .m_ack(mAck), .m_err(mErr),
      .s_cyc(sCyc), .s_stb(sStb), .s_we(sWe), .s_adr(sAdr), .s_dat_w(sDatW), .s_sel(sSel),
      .s_dat_r(sDatR), .s_ack(sAck), .s_err(sErr),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are checked 1-2 time units after the rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called in an IDLE cycle with both masters requesting; serves one ack to the expected owner.
   task automatic applyStimulus(input int expG, input logic [31:0] expAdr);
      checkOutput("rr_idle_busy", 64'(busy), 64'd0);
      nextCycle();
      checkOutput("rr_grant", 64'(grant), 64'(expG));
      checkOutput("rr_scyc", 64'(sCyc), 64'd1);
      checkOutput("rr_sadr", 64'(sAdr), 64'(expAdr));
      sAck = 1'b1;
      mCyc[expG] = 1'b0;
      mStb[expG] = 1'b0;
      settle();
      checkOutput("rr_ack", 64'(mAck), 64'(2'b01 << expG));
      nextCycle();
      sAck = 1'b0;
      mCyc[expG] = 1'b1;
      mStb[expG] = 1'b1;
   endtask

   initial begin
      rstN  = 1'b0;
      mCyc  = 2'b11;
      mStb  = 2'b00;
      mWe   = 2'b00;
      mAdr  = {32'h0000_2000, 32'h0000_1000};
      mDatW = {32'h2222_2222, 32'h1111_1111};
      mSel  = 8'hFF;
      sDatR = '0;
      sAck  = 1'b0;
      sErr  = 1'b0;

      $display("[TB] reset");
      nextCycle();
      nextCycle();
      checkOutput("rst_scyc", 64'(sCyc), 64'd0);
      checkOutput("rst_ack", 64'(mAck), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_grant", 64'(grant), 64'd1);
      mCyc = 2'b00;
      rstN = 1'b1;
      nextCycle();

      $display("[TB] single master read");
      mCyc = 2'b01;
      mStb = 2'b01;
      settle();
      checkOutput("single_latency_scyc", 64'(sCyc), 64'd0);
      nextCycle();
      checkOutput("single_scyc", 64'(sCyc), 64'd1);
      checkOutput("single_sadr", 64'(sAdr), 64'h1000);
      checkOutput("single_grant", 64'(grant), 64'd0);
      checkOutput("single_noack", 64'(mAck), 64'd0);
      nextCycle();
      nextCycle();
      sAck  = 1'b1;
      sDatR = 32'hDEAD_BEEF;
      mCyc  = 2'b00;
      mStb  = 2'b00;
      settle();
      checkOutput("single_ack", 64'(mAck), 64'b01);
      checkOutput("single_datr", 64'(mDatR), 64'hDEAD_BEEF);
      checkOutput("single_scyc_drop", 64'(sCyc), 64'd0);
      nextCycle();
      sAck = 1'b0;
      checkOutput("single_idle", 64'(busy), 64'd0);

      $display("[TB] round robin");
      rstN = 1'b0;
      nextCycle();
      rstN = 1'b1;
      mCyc = 2'b11;
      mStb = 2'b11;
      mAdr = {32'h0000_2000, 32'h0000_1004};
      applyStimulus(0, 32'h1004);
      applyStimulus(1, 32'h2000);
      applyStimulus(0, 32'h1004);
      applyStimulus(1, 32'h2000);

      $display("[TB] hold");
      mCyc = 2'b10;
      mStb = 2'b10;
      nextCycle();
      checkOutput("hold_grant1", 64'(grant), 64'd1);
      mCyc = 2'b11;
      mStb = 2'b11;
      for (int b = 0; b < 4; b++) begin
         sAck = 1'b1;
         settle();
         checkOutput("hold_ack_m1", 64'(mAck), 64'b10);
         checkOutput("hold_sadr", 64'(sAdr), 64'h2000);
         nextCycle();
         sAck = 1'b0;
         settle();
         checkOutput("hold_gap", 64'(mAck), 64'd0);
         nextCycle();
      end
      mCyc[1] = 1'b0;
      mStb[1] = 1'b0;
      settle();
      checkOutput("hold_scyc_drop", 64'(sCyc), 64'd0);
      nextCycle();
      checkOutput("hold_idle", 64'(busy), 64'd0);
      nextCycle();
      checkOutput("hold_grant0", 64'(grant), 64'd0);
      checkOutput("hold_sadr0", 64'(sAdr), 64'h1004);
      sAck = 1'b1;
      mCyc = 2'b00;
      mStb = 2'b00;
      settle();
      checkOutput("hold_ack_m0", 64'(mAck), 64'b01);
      nextCycle();
      sAck = 1'b0;

      $display("[TB] watchdog timeout");
      mCyc = 2'b01;
      mStb = 2'b01;
      nextCycle();
      checkOutput("to_stb", 64'(sStb), 64'd1);
      for (int k = 1; k < 8; k++) begin
         nextCycle();
         checkOutput("to_noerr", 64'(mErr), 64'd0);
      end
      nextCycle();
      checkOutput("to_err", 64'(mErr), 64'b01);
      checkOutput("to_busy", 64'(busy), 64'd1);
      nextCycle();
      checkOutput("to_err_single", 64'(mErr), 64'd0);
      checkOutput("to_scyc", 64'(sCyc), 64'd0);
      checkOutput("to_abort_busy", 64'(busy), 64'd1);
      sAck = 1'b1;
      settle();
      checkOutput("to_late_ack", 64'(mAck), 64'd0);
      nextCycle();
      checkOutput("to_still_busy", 64'(busy), 64'd1);
      mCyc = 2'b00;
      mStb = 2'b00;
      nextCycle();
      checkOutput("to_idle", 64'(busy), 64'd0);
      checkOutput("to_idle_ack", 64'(mAck), 64'd0);
      sAck = 1'b0;

      $display("[TB] reset mid-cycle");
      mCyc = 2'b01;
      mStb = 2'b01;
      nextCycle();
      checkOutput("mid_grant0", 64'(grant), 64'd0);
      checkOutput("mid_scyc", 64'(sCyc), 64'd1);
      rstN = 1'b0;
      nextCycle();
      checkOutput("mid_rst_scyc", 64'(sCyc), 64'd0);
      checkOutput("mid_rst_grant", 64'(grant), 64'd1);
      checkOutput("mid_rst_busy", 64'(busy), 64'd0);
      rstN = 1'b1;
      nextCycle();
      checkOutput("mid_regrant", 64'(grant), 64'd0);
      checkOutput("mid_regrant_scyc", 64'(sCyc), 64'd1);
      mCyc = 2'b00;
      mStb = 2'b00;
      nextCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
      $finish;
   end

endmodule
